// File: rtl/mfm_pkg.sv
// mfm_pkg: shared definitions for the MFM sector read path.
//   state_t     - sequencer states
//   ERR_*       - status codes reported on err with done
//   mark bytes  - A1 sync, F8 data address mark, FE/FF/FC/FD ID marks
//   CRC_*       - CRC-16-CCITT polynomial and preset value
//   crc16_byte  - one byte-wide, MSB-first CRC update
package mfm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_ID,
        ST_ID_MARK,
        ST_ID_FIELDS,
        ST_ID_CHECK,
        ST_WAIT_DAM,
        ST_DAM_MARK,
        ST_DATA,
        ST_DATA_CRC,
        ST_DATA_CHECK,
        ST_FINISH
    } state_t;

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_NOT_FOUND = 3'd1;
    localparam logic [2:0] ERR_ID_CRC    = 3'd2;
    localparam logic [2:0] ERR_NO_DAM    = 3'd3;
    localparam logic [2:0] ERR_DATA_CRC  = 3'd4;
    localparam logic [2:0] ERR_ABORTED   = 3'd5;

    localparam logic [7:0] SYNC_A1 = 8'hA1;
    localparam logic [7:0] DAM_F8  = 8'hF8;
    localparam logic [7:0] IDAM_FE = 8'hFE;  // cyl[9:8] = 0
    localparam logic [7:0] IDAM_FF = 8'hFF;  // cyl[9:8] = 1
    localparam logic [7:0] IDAM_FC = 8'hFC;  // cyl[9:8] = 2
    localparam logic [7:0] IDAM_FD = 8'hFD;  // cyl[9:8] = 3

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  din);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        c = crc_in;
        d = din;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[15] ^ d[7];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC_POLY;
            d  = {d[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/mfm_crc16.sv
// mfm_crc16: registered byte-wide CRC-16-CCITT (poly 0x1021, MSB first).
//   clk_50  - clock
//   reset   - synchronous active-low reset, clears crc to 0
//   preset  - restart from 0xFFFF; with en the din byte is absorbed
//             on top of the preset in the same cycle
//   en      - absorb din this cycle
//   din     - byte to absorb
//   crc     - current CRC register
module mfm_crc16
    import mfm_pkg::*;
(
    input  logic        clk_50,
    input  logic        reset,
    input  logic        preset,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc16_byte(preset ? CRC_INIT : crc, din);
        end else if (preset) begin
            crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/mfm_sector_sequencer.sv
// mfm_sector_sequencer: reads one sector from the decoded MFM byte stream.
// Hunts ID fields after each A1 sync, matches them against the commanded
// cylinder/head/sector, checks the ID CRC, then writes the data field
// payload into an external sector RAM and checks the data CRC.
//   clk_50, reset          - clock, synchronous active-low reset
//   sync                   - A1 address-mark sync pulse
//   byte_in, byte_valid    - decoded byte stream
//   cmd_start, cmd_abort   - host command pulses
//   cmd_cyl/head/sector    - read target, sampled with cmd_start
//   busy, done, err        - command status (err valid with done, held)
//   wr_en, wr_addr, wr_data- sector RAM write port
module mfm_sector_sequencer
    import mfm_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int MAX_ID_TRIES = 64,
    parameter int DAM_WINDOW   = 64
) (
    input  logic                            clk_50,
    input  logic                            reset,
    input  logic                            sync,
    input  logic [7:0]                      byte_in,
    input  logic                            byte_valid,
    input  logic                            cmd_start,
    input  logic                            cmd_abort,
    input  logic [9:0]                      cmd_cyl,
    input  logic [2:0]                      cmd_head,
    input  logic [7:0]                      cmd_sector,
    output logic                            busy,
    output logic                            done,
    output logic [2:0]                      err,
    output logic                            wr_en,
    output logic [$clog2(SECTOR_BYTES)-1:0] wr_addr,
    output logic [7:0]                      wr_data
);

    localparam int AW = $clog2(SECTOR_BYTES);
    localparam int TW = $clog2(MAX_ID_TRIES + 1);
    localparam int WW = $clog2(DAM_WINDOW + 1);

    state_t          state;
    logic [9:0]      tgt_cyl;
    logic [2:0]      tgt_head;
    logic [7:0]      tgt_sector;
    logic [9:0]      id_cyl;
    logic [2:0]      id_head;
    logic [7:0]      id_sector;
    logic [2:0]      fld_cnt;
    logic [TW-1:0]   tries;
    logic [WW-1:0]   win_cnt;
    logic [AW-1:0]   byte_cnt;

    logic [15:0]     crc;
    logic            crc_en;
    logic [7:0]      crc_din;
    logic            id_match;
    logic [TW-1:0]   tries_inc;
    logic [WW-1:0]   win_inc;

    // A sync both presets the CRC and feeds it the A1 byte; a byte arriving
    // on the same cycle as a sync is dropped.
    always_comb begin
        crc_en    = sync | byte_valid;
        crc_din   = sync ? SYNC_A1 : byte_in;
        id_match  = (id_cyl == tgt_cyl) && (id_head == tgt_head) &&
                    (id_sector == tgt_sector);
        tries_inc = tries + 1'b1;
        win_inc   = win_cnt + 1'b1;
    end

    mfm_crc16 u_crc (
        .clk_50 (clk_50),
        .reset  (reset),
        .preset (sync),
        .en     (crc_en),
        .din    (crc_din),
        .crc    (crc)
    );

    always_ff @(posedge clk_50) begin
        if (!reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_OK;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            tgt_cyl    <= '0;
            tgt_head   <= '0;
            tgt_sector <= '0;
            id_cyl     <= '0;
            id_head    <= '0;
            id_sector  <= '0;
            fld_cnt    <= '0;
            tries      <= '0;
            win_cnt    <= '0;
            byte_cnt   <= '0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            // Address advances after each write, so it always shows the
            // index of the next payload byte and wraps after the last one.
            if (wr_en) wr_addr <= wr_addr + 1'b1;

            if (busy && cmd_abort) begin
                state <= ST_FINISH;
                err   <= ERR_ABORTED;
                done  <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_start) begin
                            tgt_cyl    <= cmd_cyl;
                            tgt_head   <= cmd_head;
                            tgt_sector <= cmd_sector;
                            err        <= ERR_OK;
                            tries      <= '0;
                            busy       <= 1'b1;
                            state      <= ST_WAIT_ID;
                        end
                    end

                    ST_WAIT_ID: begin
                        if (sync) state <= ST_ID_MARK;
                    end

                    ST_ID_MARK: begin
                        if (byte_valid && !sync) begin
                            fld_cnt <= '0;
                            state   <= ST_ID_FIELDS;
                            case (byte_in)
                                IDAM_FE: id_cyl[9:8] <= 2'd0;
                                IDAM_FF: id_cyl[9:8] <= 2'd1;
                                IDAM_FC: id_cyl[9:8] <= 2'd2;
                                IDAM_FD: id_cyl[9:8] <= 2'd3;
                                default: state <= ST_WAIT_ID;
                            endcase
                        end
                    end

                    ST_ID_FIELDS: begin
                        if (sync) begin
                            state <= ST_ID_MARK;
                        end else if (byte_valid) begin
                            case (fld_cnt)
                                3'd0:    id_cyl[7:0] <= byte_in;
                                3'd1:    id_head     <= byte_in[2:0];
                                3'd2:    id_sector   <= byte_in;
                                default: ;
                            endcase
                            if (fld_cnt == 3'd4) begin
                                fld_cnt <= '0;
                                state   <= ST_ID_CHECK;
                            end else begin
                                fld_cnt <= fld_cnt + 1'b1;
                            end
                        end
                    end

                    // CRC register now holds the residue of the whole ID
                    // field. Bytes cannot follow the CRC this closely, but a
                    // sync is still honoured so it is not lost.
                    ST_ID_CHECK: begin
                        tries <= tries_inc;
                        if (id_match) begin
                            if (crc == 16'h0000) begin
                                win_cnt <= '0;
                                state   <= sync ? ST_DAM_MARK : ST_WAIT_DAM;
                            end else begin
                                err   <= ERR_ID_CRC;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_FINISH;
                            end
                        end else if (tries_inc == TW'(MAX_ID_TRIES)) begin
                            err   <= ERR_NOT_FOUND;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_FINISH;
                        end else begin
                            state <= sync ? ST_ID_MARK : ST_WAIT_ID;
                        end
                    end

                    ST_WAIT_DAM: begin
                        if (sync) begin
                            state <= ST_DAM_MARK;
                        end else if (byte_valid) begin
                            win_cnt <= win_inc;
                            if (win_inc == WW'(DAM_WINDOW)) begin
                                err   <= ERR_NO_DAM;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_FINISH;
                            end
                        end
                    end

                    ST_DAM_MARK: begin
                        if (byte_valid && !sync) begin
                            if (byte_in == DAM_F8) begin
                                wr_addr  <= '0;
                                byte_cnt <= '0;
                                state    <= ST_DATA;
                            end else begin
                                err   <= ERR_NO_DAM;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_FINISH;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (sync) begin
                            state <= ST_ID_MARK;
                        end else if (byte_valid) begin
                            wr_en    <= 1'b1;
                            wr_data  <= byte_in;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (byte_cnt == '1) begin
                                fld_cnt <= '0;
                                state   <= ST_DATA_CRC;
                            end
                        end
                    end

                    ST_DATA_CRC: begin
                        if (sync) begin
                            state <= ST_ID_MARK;
                        end else if (byte_valid) begin
                            if (fld_cnt == 3'd1) begin
                                fld_cnt <= '0;
                                state   <= ST_DATA_CHECK;
                            end else begin
                                fld_cnt <= 3'd1;
                            end
                        end
                    end

                    ST_DATA_CHECK: begin
                        err   <= (crc == 16'h0000) ? ERR_OK : ERR_DATA_CRC;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_FINISH;
                    end

                    ST_FINISH: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mfm_sector_sequencer.sv
// tb_mfm_sector_sequencer: scoreboard bench for mfm_sector_sequencer.
// Expected RAM writes and done/err results are queued as stimulus is driven
// and compared by a monitor when the DUT produces them.
module tb_mfm_sector_sequencer;

    localparam int SB = 512;
    localparam int AW = $clog2(SB);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk_50 = 1'b0;
    logic          reset;
    logic          sync;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          cmd_start;
    logic          cmd_abort;
    logic [9:0]    cmd_cyl;
    logic [2:0]    cmd_head;
    logic [7:0]    cmd_sector;
    logic          busy;
    logic          done;
    logic [2:0]    err;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int done_cyc     = 0;
    int cyc          = 0;
    int last_bv_cyc  = 0;
    int abort_cyc    = 0;

    wr_t        exp_wr[$];
    logic [2:0] exp_done[$];

    mfm_sector_sequencer #(
        .SECTOR_BYTES (SB),
        .MAX_ID_TRIES (4),
        .DAM_WINDOW   (64)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .sync       (sync),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .cmd_start  (cmd_start),
        .cmd_abort  (cmd_abort),
        .cmd_cyl    (cmd_cyl),
        .cmd_head   (cmd_head),
        .cmd_sector (cmd_sector),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk_50) begin
        if (wr_en) begin
            tests_run++;
            if (exp_wr.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write: addr=%0d data=%02h, none required", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    tests_failed++;
                    $display("FAIL ram_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            tests_run++;
            if (exp_done.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_done: err=%0d, no done required", err);
            end else begin
                logic [2:0] e_err;
                e_err = exp_done.pop_front();
                if (err !== e_err) begin
                    tests_failed++;
                    $display("FAIL done_err: got err=%0d, required %0d", err, e_err);
                end
            end
        end
    end

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        byte_in     = b;
        byte_valid  = 1'b1;
        last_bv_cyc = cyc;
        tick();
        byte_valid  = 1'b0;
        tick();
    endtask

    task automatic send_sync();
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
    endtask

    task automatic start_cmd(input logic [9:0] cyl, input logic [2:0] head, input logic [7:0] sec);
        tick();
        cmd_cyl    = cyl;
        cmd_head   = head;
        cmd_sector = sec;
        cmd_start  = 1'b1;
        tick();
        cmd_start  = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || err !== 3'd0) begin
            tests_failed++;
            $display("FAIL start_accept: busy=%b err=%0d, required busy=1 err=0", busy, err);
        end
    endtask

    // Sends sync plus the first nbytes of an ID field (6 = complete).
    task automatic send_id(input logic [9:0] cyl, input logic [2:0] head, input logic [7:0] sec,
                           input bit bad_crc, input int nbytes);
        logic [7:0]  f [6];
        logic [15:0] c;
        case (cyl[9:8])
            2'd0:    f[0] = 8'hFE;
            2'd1:    f[0] = 8'hFF;
            2'd2:    f[0] = 8'hFC;
            default: f[0] = 8'hFD;
        endcase
        f[1] = cyl[7:0];
        f[2] = {5'b0, head};
        f[3] = sec;
        c = ref_crc(16'hFFFF, 8'hA1);
        for (int i = 0; i < 4; i++) c = ref_crc(c, f[i]);
        f[4] = c[15:8];
        f[5] = c[7:0] ^ (bad_crc ? 8'h01 : 8'h00);
        send_sync();
        for (int i = 0; i < nbytes; i++) send_byte(f[i]);
    endtask

    // Sends sync, F8 and nbytes of i mod 256 payload, queueing the writes.
    // The CRC covers the intended payload, so a corrupted byte breaks it.
    task automatic send_data(input int nbytes, input int corrupt_idx, input bit with_crc);
        logic [15:0] c;
        logic [7:0]  b;
        wr_t         e;
        send_sync();
        send_byte(8'hF8);
        c = ref_crc(ref_crc(16'hFFFF, 8'hA1), 8'hF8);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(i);
            c = ref_crc(c, b);
            if (i == corrupt_idx) b = b ^ 8'h5A;
            e.addr = AW'(i);
            e.data = b;
            exp_wr.push_back(e);
            send_byte(b);
        end
        if (with_crc) begin
            send_byte(c[15:8]);
            send_byte(c[7:0]);
        end
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        tests_run++;
        if (done_cnt == d0) begin
            tests_failed++;
            $display("FAIL %s: no done within %0d cycles, required one", name, budget);
        end
        tick();
    endtask

    task automatic check_idle(input logic [2:0] e_err, input string name);
        tests_run++;
        if (busy !== 1'b0 || err !== e_err || exp_wr.size() != 0 || exp_done.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: busy=%b err=%0d pending_wr=%0d pending_done=%0d, required busy=0 err=%0d pending 0/0",
                     name, busy, err, exp_wr.size(), exp_done.size(), e_err);
        end
    endtask

    task automatic test_reset();
        int d0;
        repeat (3) tick();
        tests_run++;
        if ({busy, done, err, wr_en, wr_addr, wr_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%0d wr_en=%b addr=%0d data=%02h, required all 0",
                     busy, done, err, wr_en, wr_addr, wr_data);
        end
        reset = 1'b1;
        tick();
        // Stream activity and a lone abort in IDLE do nothing.
        d0 = done_cnt;
        send_sync();
        send_byte(8'hF8);
        send_byte(8'h12);
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            tests_failed++;
            $display("FAIL idle_ignore: busy=%b dones=%0d, required busy=0 dones=0", busy, done_cnt - d0);
        end
        // Start and abort together in IDLE: start wins.
        tick();
        cmd_cyl = 10'h105; cmd_head = 3'd2; cmd_sector = 8'd7;
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done_cnt != d0) begin
            tests_failed++;
            $display("FAIL start_over_abort: busy=%b dones=%0d, required busy=1 dones=0", busy, done_cnt - d0);
        end
        exp_done.push_back(3'd5);
        d0 = done_cnt;
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(d0, 10, "abort_after_start");
        check_idle(3'd5, "abort_after_start_idle");
    endtask

    task automatic test_good_read(input bit stray_start);
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        send_id(10'h105, 3'd2, 8'd7, 1'b0, 6);
        if (stray_start) begin
            tick();
            cmd_sector = 8'd9;
            cmd_start  = 1'b1;
            tick();
            cmd_start  = 1'b0;
        end
        for (int i = 0; i < 20; i++) send_byte(8'h4E);
        d0 = done_cnt;
        exp_done.push_back(3'd0);
        send_data(SB, -1, 1'b1);
        wait_done(d0, 20, "good_read");
        tests_run++;
        if (done_cyc - last_bv_cyc != 2) begin
            tests_failed++;
            $display("FAIL done_latency: got %0d cycles, required 2", done_cyc - last_bv_cyc);
        end
        repeat (3) tick();
        check_idle(3'd0, "good_read_idle");
    endtask

    task automatic test_data_crc_err();
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        send_id(10'h105, 3'd2, 8'd7, 1'b0, 6);
        d0 = done_cnt;
        exp_done.push_back(3'd4);
        send_data(SB, 300, 1'b1);
        wait_done(d0, 20, "data_crc_err");
        check_idle(3'd4, "data_crc_err_idle");
    endtask

    task automatic test_id_crc_err();
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        d0 = done_cnt;
        exp_done.push_back(3'd2);
        send_id(10'h105, 3'd2, 8'd7, 1'b1, 6);
        wait_done(d0, 20, "id_crc_err");
        send_data(0, -1, 1'b0);
        check_idle(3'd2, "id_crc_err_idle");
    endtask

    task automatic test_not_found();
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        d0 = done_cnt;
        // A truncated ID and a non-mark byte are not tries.
        send_id(10'h105, 3'd2, 8'd3, 1'b0, 3);
        send_sync();
        send_byte(8'h55);
        for (int t = 0; t < 3; t++) send_id(10'h105, 3'd2, 8'd3, 1'b0, 6);
        repeat (4) tick();
        tests_run++;
        if (done_cnt != d0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL tries_early: dones=%0d busy=%b after 3 tries, required 0 and 1", done_cnt - d0, busy);
        end
        exp_done.push_back(3'd1);
        send_id(10'h105, 3'd2, 8'd3, 1'b0, 6);
        wait_done(d0, 20, "not_found");
        tests_run++;
        if (done_cyc - last_bv_cyc != 2) begin
            tests_failed++;
            $display("FAIL not_found_latency: got %0d cycles, required 2", done_cyc - last_bv_cyc);
        end
        check_idle(3'd1, "not_found_idle");
    endtask

    task automatic test_no_dam();
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        send_id(10'h105, 3'd2, 8'd7, 1'b0, 6);
        d0 = done_cnt;
        for (int i = 0; i < 63; i++) send_byte(8'h4E);
        repeat (3) tick();
        tests_run++;
        if (done_cnt != d0) begin
            tests_failed++;
            $display("FAIL dam_window_early: done after 63 bytes, required none");
        end
        exp_done.push_back(3'd3);
        send_byte(8'h4E);
        wait_done(d0, 10, "dam_window");
        check_idle(3'd3, "dam_window_idle");

        start_cmd(10'h105, 3'd2, 8'd7);
        send_id(10'h105, 3'd2, 8'd7, 1'b0, 6);
        d0 = done_cnt;
        exp_done.push_back(3'd3);
        send_sync();
        send_byte(8'hFB);
        wait_done(d0, 10, "bad_dam");
        check_idle(3'd3, "bad_dam_idle");
    endtask

    task automatic test_abort();
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        send_id(10'h105, 3'd2, 8'd7, 1'b0, 6);
        send_data(100, -1, 1'b0);
        d0 = done_cnt;
        exp_done.push_back(3'd5);
        tick();
        cmd_abort = 1'b1;
        abort_cyc = cyc;
        tick();
        cmd_abort = 1'b0;
        wait_done(d0, 10, "abort");
        tests_run++;
        if (done_cyc - abort_cyc != 1) begin
            tests_failed++;
            $display("FAIL abort_latency: got %0d cycles, required 1", done_cyc - abort_cyc);
        end
        for (int i = 0; i < 5; i++) send_byte(8'(100 + i));
        check_idle(3'd5, "abort_idle");
        test_good_read(1'b0);
    endtask

    task automatic test_reset_mid_data();
        int d0;
        start_cmd(10'h105, 3'd2, 8'd7);
        send_id(10'h105, 3'd2, 8'd7, 1'b0, 6);
        send_data(50, -1, 1'b0);
        d0 = done_cnt;
        tick();
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        reset      = 1'b0;
        tick();
        byte_valid = 1'b0;
        tests_run++;
        if ({busy, done, err, wr_en, wr_addr, wr_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_data: busy=%b done=%b err=%0d wr_en=%b addr=%0d data=%02h, required all 0",
                     busy, done, err, wr_en, wr_addr, wr_data);
        end
        tick();
        reset = 1'b1;
        repeat (20) tick();
        tests_run++;
        if (done_cnt != d0) begin
            tests_failed++;
            $display("FAIL reset_no_done: %0d done pulses, required 0", done_cnt - d0);
        end
        check_idle(3'd0, "reset_mid_data_idle");
    endtask

    initial begin
        reset      = 1'b0;
        sync       = 1'b0;
        byte_in    = '0;
        byte_valid = 1'b0;
        cmd_start  = 1'b0;
        cmd_abort  = 1'b0;
        cmd_cyl    = '0;
        cmd_head   = '0;
        cmd_sector = '0;
        test_reset();
        test_good_read(1'b1);
        test_data_crc_err();
        test_id_crc_err();
        test_not_found();
        test_no_dam();
        test_abort();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

endmodule
